// File: rtl/stoch_pkg.sv
// Shared stochastic-computing package: FSM states and default width.
package stoch_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;
  localparam int STOCH_WIDTH_DEFAULT = 8;
endpackage

// File: rtl/stoch_ones_counter.sv
// Window counter: counts accepted samples and ones; clear has priority over enable.
module stoch_ones_counter
  import stoch_pkg::*;
#(
  parameter int WIDTH = STOCH_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] sample_cnt_o,
  output logic [WIDTH:0]   ones_cnt_o,
  output logic             last_o
);
  logic [WIDTH-1:0] sample_cnt_q;
  logic [WIDTH:0]   ones_cnt_q;

  // sample_cnt wraps to 0 after the last sample; ones_cnt can reach 2**WIDTH
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      sample_cnt_q <= '0;
      ones_cnt_q   <= '0;
    end else if (en_i) begin
      sample_cnt_q <= sample_cnt_q + 1'b1;
      ones_cnt_q   <= ones_cnt_q + {{WIDTH{1'b0}}, bit_i};
    end
  end

  assign sample_cnt_o = sample_cnt_q;
  assign ones_cnt_o   = ones_cnt_q;
  assign last_o       = &sample_cnt_q;
endmodule

// File: rtl/stoch_stream_decoder.sv
// Stochastic-to-binary decoder: ones count over 2**WIDTH accepted bits, saturated.
// Build option: STOCH_DEC_FREERUN_EN -- windows run back-to-back after the first start.
module stoch_stream_decoder
  import stoch_pkg::*;
#(
  parameter int WIDTH = STOCH_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  input  logic             result_ready
);
  localparam logic [WIDTH+1:0] MAX_SUM = {2'b00, {WIDTH{1'b1}}};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cnt_clr, cnt_en, cnt_last;
  logic [WIDTH-1:0] sample_cnt;
  logic [WIDTH:0]   ones_cnt;
  logic [WIDTH+1:0] final_sum;

  stoch_ones_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (cnt_clr),
    .en_i         (cnt_en),
    .bit_i        (bit_in),
    .sample_cnt_o (sample_cnt),
    .ones_cnt_o   (ones_cnt),
    .last_o       (cnt_last)
  );

  // Count including the final bit, widened so the all-ones window can be clamped
  assign final_sum = {1'b0, ones_cnt} + {{(WIDTH+1){1'b0}}, bit_in};

  // State and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
    end
  end

  // Next-state, counter control and saturated result capture
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_clr = 1'b1;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (bit_valid) begin
          cnt_en = 1'b1;
          if (cnt_last) begin
            state_d  = DONE;
            result_d = (final_sum > MAX_SUM) ? MAX_SUM[WIDTH-1:0] : final_sum[WIDTH-1:0];
          end
        end
      end
      DONE: begin
        if (result_ready) begin
`ifdef STOCH_DEC_FREERUN_EN
          cnt_clr = 1'b1;
          state_d = ACCUM;
`else
          state_d = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bit_ready    = (state_q == ACCUM);
  assign busy         = (state_q != IDLE);
  assign result_valid = (state_q == DONE);
  assign result       = result_q;
endmodule
